// File: rtl/vol_ramp_ctrl.sv
// Per-channel volume ramp controller: walks all channels once per frame tick and slews
// each current volume toward its target by at most its step. Optional soft mute: VOL_RAMP_MUTE_EN.
module vol_ramp_ctrl #(
    parameter int NUM_CH      = 8,
    parameter int NUM_CH_LOG2 = 3,
    parameter int VOL_WIDTH   = 32,
    parameter int STEP_WIDTH  = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en_i,
    input  logic [NUM_CH_LOG2-1:0]      wr_ch_i,
    input  logic [VOL_WIDTH-1:0]        wr_vol_i,
    input  logic [STEP_WIDTH-1:0]       wr_step_i,
    input  logic                        tick_i,
`ifdef VOL_RAMP_MUTE_EN
    input  logic [NUM_CH-1:0]           mute_i,
`endif
    output logic [NUM_CH*VOL_WIDTH-1:0] vol_o,
    output logic [NUM_CH-1:0]           ramping_o,
    output logic                        busy_o,
    output logic                        overrun_o
);

    // state  | meaning
    // S_IDLE | waiting for a tick (or a tick remembered during the last scan)
    // S_SCAN | updating channel idx this cycle, one channel per clock
    typedef enum logic {S_IDLE, S_SCAN} state_t;

    localparam logic [NUM_CH_LOG2-1:0] LAST_CH = NUM_CH_LOG2'(NUM_CH - 1);

    state_t                   state, state_nxt;
    logic [NUM_CH_LOG2-1:0]   idx, idx_nxt;
    logic                     pending, pending_nxt;
    logic                     overrun, overrun_nxt;
    logic                     upd_en;

    logic [VOL_WIDTH-1:0]     tgt     [NUM_CH];
    logic [STEP_WIDTH-1:0]    step    [NUM_CH];
    logic [VOL_WIDTH-1:0]     cur     [NUM_CH];
    logic [VOL_WIDTH-1:0]     eff_tgt [NUM_CH];
    logic [NUM_CH-1:0]        ramping;

    logic [VOL_WIDTH-1:0]     cur_sel, tgt_sel, step_ext, gap, new_val;
    logic [VOL_WIDTH:0]       sum;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
`ifdef VOL_RAMP_MUTE_EN
            eff_tgt[i] = mute_i[i] ? '0 : tgt[i];
`else
            eff_tgt[i] = tgt[i];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            idx     <= '0;
            pending <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            pending <= pending_nxt;
            overrun <= overrun_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        pending_nxt = pending;
        overrun_nxt = overrun;
        upd_en      = 1'b0;
        case (state)
            S_IDLE: begin
                if (tick_i || pending) begin
                    state_nxt   = S_SCAN;
                    idx_nxt     = '0;
                    pending_nxt = 1'b0;
                end
            end
            S_SCAN: begin
                upd_en = 1'b1;
                if (tick_i) begin
                    if (pending) overrun_nxt = 1'b1;
                    else         pending_nxt = 1'b1;
                end
                if (idx == LAST_CH) begin
                    // Back-to-back scan when a tick is waiting; no idle gap.
                    if (pending || tick_i) begin
                        idx_nxt     = '0;
                        pending_nxt = 1'b0;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end else begin
                    idx_nxt = idx + 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        cur_sel  = cur[idx];
        tgt_sel  = eff_tgt[idx];
        step_ext = VOL_WIDTH'(step[idx]);
        sum      = {1'b0, cur_sel} + {1'b0, step_ext};
        gap      = cur_sel - tgt_sel;
        new_val  = cur_sel;
        if (step_ext == '0) begin
            new_val = tgt_sel;
        end else if (cur_sel < tgt_sel) begin
            new_val = (sum >= {1'b0, tgt_sel}) ? tgt_sel : sum[VOL_WIDTH-1:0];
        end else if (cur_sel > tgt_sel) begin
            new_val = (gap > step_ext) ? (cur_sel - step_ext) : tgt_sel;
        end
    end

    // Register reads above see pre-write tgt/step, so a colliding write lands next tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                tgt[i]  <= '0;
                step[i] <= '0;
                cur[i]  <= '0;
            end
            ramping <= '0;
        end else begin
            if (wr_en_i) begin
                tgt[wr_ch_i]  <= wr_vol_i;
                step[wr_ch_i] <= wr_step_i;
            end
            if (upd_en) cur[idx] <= new_val;
            for (int i = 0; i < NUM_CH; i++) begin
                ramping[i] <= (cur[i] != eff_tgt[i]);
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_vol
        assign vol_o[g*VOL_WIDTH +: VOL_WIDTH] = cur[g];
    end

    assign ramping_o = ramping;
    assign busy_o    = (state == S_SCAN);
    assign overrun_o = overrun;

endmodule

// File: tb/tb_vol_ramp_ctrl.sv
// Bench for vol_ramp_ctrl: directed scenarios plus random writes/ticks checked against
// a timeline model (scan start cycles, per-channel arithmetic).
module tb_vol_ramp_ctrl;

    localparam int NCH = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_en_i;
    logic [2:0]        wr_ch_i;
    logic [31:0]       wr_vol_i;
    logic [15:0]       wr_step_i;
    logic              tick_i;
    logic [NCH*32-1:0] vol_o;
    logic [NCH-1:0]    ramping_o;
    logic              busy_o;
    logic              overrun_o;
`ifdef VOL_RAMP_MUTE_EN
    logic [NCH-1:0]    mute_i = '0;
`endif

    vol_ramp_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (wr_en_i),
        .wr_ch_i   (wr_ch_i),
        .wr_vol_i  (wr_vol_i),
        .wr_step_i (wr_step_i),
        .tick_i    (tick_i),
`ifdef VOL_RAMP_MUTE_EN
        .mute_i    (mute_i),
`endif
        .vol_o     (vol_o),
        .ramping_o (ramping_o),
        .busy_o    (busy_o),
        .overrun_o (overrun_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    longint   m_tgt [NCH];
    longint   m_step[NCH];
    longint   m_cur [NCH];
    bit [7:0] m_ramp;
    bit       m_ovr;
    int       starts[$];
    int       next_start;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h cyc=%0d", tag, obs, exp, cyc);
        end
    endtask

    function automatic bit in_scan(int n);
        foreach (starts[j]) if (n >= starts[j] && n <= starts[j] + NCH - 1) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_tgt[i] = 0; m_step[i] = 0; m_cur[i] = 0;
        end
        m_ramp = '0;
        m_ovr = 1'b0;
        starts.delete();
        next_start = -100;
    endfunction

    // Effect of the clock edge that ends cycle cyc, given the inputs held during it.
    function automatic void model_step(bit we, int ch, longint vol, longint stp, bit tk, bit r);
        bit [7:0] nr;
        if (r) begin
            model_reset();
            return;
        end
        for (int i = 0; i < NCH; i++) nr[i] = (m_cur[i] != m_tgt[i]);
        foreach (starts[j]) begin
            if (cyc >= starts[j] && cyc <= starts[j] + NCH - 1) begin
                int k = cyc - starts[j];
                if (m_step[k] == 0)             m_cur[k] = m_tgt[k];
                else if (m_cur[k] < m_tgt[k])   m_cur[k] = (m_cur[k] + m_step[k] > m_tgt[k]) ? m_tgt[k] : m_cur[k] + m_step[k];
                else if (m_cur[k] > m_tgt[k])   m_cur[k] = (m_cur[k] - m_step[k] < m_tgt[k]) ? m_tgt[k] : m_cur[k] - m_step[k];
            end
        end
        m_ramp = nr;
        if (we) begin
            m_tgt[ch] = vol; m_step[ch] = stp;
        end
        if (tk) begin
            if (cyc >= next_start + NCH - 1) begin
                next_start = cyc + 1;
                starts.push_back(next_start);
            end else if (cyc < next_start) begin
                m_ovr = 1'b1;
            end else begin
                next_start += NCH;
                starts.push_back(next_start);
            end
        end
        while (starts.size() > 0 && starts[0] + NCH - 1 < cyc) void'(starts.pop_front());
    endfunction

    task automatic check_all();
        for (int i = 0; i < NCH; i++) chk($sformatf("vol%0d", i), {32'h0, vol_o[i*32 +: 32]}, m_cur[i]);
        chk("ramping", {56'h0, ramping_o}, {56'h0, m_ramp});
        chk("busy", {63'h0, busy_o}, {63'h0, in_scan(cyc)});
        chk("overrun", {63'h0, overrun_o}, {63'h0, m_ovr});
    endtask

    task automatic drive(input bit we, input int ch, input logic [31:0] vol,
                         input logic [15:0] stp, input bit tk, input bit r);
        rst = r; wr_en_i = we; wr_ch_i = ch[2:0]; wr_vol_i = vol; wr_step_i = stp; tick_i = tk;
        model_step(we, ch, longint'(vol), longint'(stp), tk, r);
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 0, 32'h0, 16'h0, 1'b0, 1'b0);
    endtask

    task automatic wr(input int ch, input logic [31:0] vol, input logic [15:0] stp);
        drive(1'b1, ch, vol, stp, 1'b0, 1'b0);
    endtask

    task automatic tick();
        drive(1'b0, 0, 32'h0, 16'h0, 1'b1, 1'b0);
    endtask

    int       bc;
    logic [31:0] exp_seq [3];

    initial begin
        model_reset();
        drive(1'b0, 0, 32'h0, 16'h0, 1'b0, 1'b1);
        drive(1'b0, 0, 32'h0, 16'h0, 1'b0, 1'b1);
        idle(3);
        chk("rst_vol", {32'h0, vol_o[255:224]} | {32'h0, vol_o[31:0]}, 64'h0);
        chk("rst_busy", {63'h0, busy_o}, 64'h0);
        chk("rst_ovr", {63'h0, overrun_o}, 64'h0);

        // Jump to unity on ch2, latency t+2+2
        wr(2, 32'h0100_0000, 16'h0);
        idle(1);
        chk("ch2_ramping_set", {63'h0, ramping_o[2]}, 64'h1);
        tick();
        bc = busy_o;
        for (int j = 1; j <= 11; j++) begin
            idle(1);
            bc += busy_o;
            if (j == 2) chk("ch2_before", {32'h0, vol_o[95:64]}, 64'h0);
            if (j == 3) chk("ch2_at_t4", {32'h0, vol_o[95:64]}, 64'h0100_0000);
        end
        chk("busy_cnt_one_scan", bc, 8);
        chk("ch2_ramping_clr", {63'h0, ramping_o[2]}, 64'h0);

        // Ramp up with clamp, then ramp down to zero
        wr(0, 32'h0000_0A00, 16'h0400);
        exp_seq[0] = 32'h400; exp_seq[1] = 32'h800; exp_seq[2] = 32'hA00;
        for (int j = 0; j < 3; j++) begin
            tick(); idle(9);
            chk("ch0_up", {32'h0, vol_o[31:0]}, {32'h0, exp_seq[j]});
        end
        wr(0, 32'h0, 16'h0400);
        exp_seq[0] = 32'h600; exp_seq[1] = 32'h200; exp_seq[2] = 32'h0;
        for (int j = 0; j < 3; j++) begin
            tick(); idle(9);
            chk("ch0_down", {32'h0, vol_o[31:0]}, {32'h0, exp_seq[j]});
        end

        // Near full scale, no wrap
        wr(5, 32'hFFFF_FF00, 16'h0);
        tick(); idle(9);
        wr(5, 32'hFFFF_FFFF, 16'hFFFF);
        tick(); idle(9);
        chk("ch5_nowrap", {32'h0, vol_o[191:160]}, 64'hFFFF_FFFF);

        // Ticks at t, t+3, t+5: pending then overrun, back-to-back scans
        tick(); bc = busy_o;
        idle(1); bc += busy_o;
        idle(1); bc += busy_o;
        tick(); bc += busy_o;
        idle(1); bc += busy_o;
        tick(); bc += busy_o;
        for (int j = 0; j < 14; j++) begin idle(1); bc += busy_o; end
        chk("busy_cnt_two_scans", bc, 16);
        chk("overrun_sticky", {63'h0, overrun_o}, 64'h1);

        // Write to ch3 while ch3 is being scanned
        wr(3, 32'h1000, 16'h0);
        tick(); idle(9);
        tick(); idle(3);
        wr(3, 32'h5000, 16'h0);
        idle(6);
        chk("ch3_old_tgt", {32'h0, vol_o[127:96]}, 64'h1000);
        tick(); idle(9);
        chk("ch3_new_tgt", {32'h0, vol_o[127:96]}, 64'h5000);

        // Reset mid-scan mutes everything the next cycle
        tick(); idle(3);
        drive(1'b0, 0, 32'h0, 16'h0, 1'b0, 1'b1);
        chk("rst_mid_ch3", {32'h0, vol_o[127:96]}, 64'h0);
        chk("rst_mid_busy", {63'h0, busy_o}, 64'h0);
        chk("rst_mid_ovr", {63'h0, overrun_o}, 64'h0);
        idle(2);

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            bit          we, tk, r;
            int          ch;
            logic [31:0] vol;
            logic [15:0] stp;
            we  = ($urandom_range(0, 3) == 0);
            tk  = ($urandom_range(0, 5) == 0);
            r   = ($urandom_range(0, 599) == 0);
            ch  = $urandom_range(0, NCH - 1);
            case ($urandom_range(0, 3))
                0:       vol = $urandom;
                1:       vol = 32'hFFFF_FFFF - $urandom_range(0, 32'h2_0000);
                default: vol = $urandom_range(0, 32'h4_0000);
            endcase
            case ($urandom_range(0, 3))
                0:       stp = 16'h0;
                1:       stp = 16'($urandom);
                default: stp = 16'($urandom_range(1, 32'h3000));
            endcase
            drive(we, ch, vol, stp, tk, r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
